// File: rtl/if_fetch.sv
// Instruction fetch: a PC register feeding a 2-entry {pc, instr} buffer toward decode.
// Define IF_MISALIGN_TRAP_EN to trap misaligned redirects: misalign_err pulses and fetch halts.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam logic [XLEN-1:0] NOP = 32'h00000013;

`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic {RUN, HALT} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  hd_pc_q, hd_pc_d, hd_instr_q, hd_instr_d;
  logic [XLEN-1:0]  tl_pc_q, tl_pc_d, tl_instr_q, tl_instr_d;
  logic             misalign_q, misalign_d;
  logic             pop_c, push_c, misaligned_c;

  assign imem_addr    = pc_q;
  assign if_valid     = (count_q != '0);
  assign if_instr     = if_valid ? hd_instr_q : NOP;
  assign if_pc        = if_valid ? hd_pc_q : '0;
  assign misalign_err = misalign_q;

  // Next-state: redirect flushes and retargets; otherwise push at tail / pop at head.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    hd_pc_d      = hd_pc_q;
    hd_instr_d   = hd_instr_q;
    tl_pc_d      = tl_pc_q;
    tl_instr_d   = tl_instr_q;
    misalign_d   = 1'b0;
    pop_c        = if_valid & id_ready;
    push_c       = (state_q == RUN) & ((count_q < CNT_W'(DEPTH)) | pop_c);
    misaligned_c = TRAP_EN & (redirect_pc[1:0] != 2'b00);

    if (redirect_valid) begin
      count_d = '0;
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      if (misaligned_c) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      if (push_c) begin
        pc_d = pc_q + XLEN'(4);
      end
      case ({push_c, pop_c})
        2'b11: begin
          // Count unchanged; the older survivor moves to the head.
          if (count_q == CNT_W'(1)) begin
            hd_pc_d    = pc_q;
            hd_instr_d = imem_instr;
          end else begin
            hd_pc_d    = tl_pc_q;
            hd_instr_d = tl_instr_q;
            tl_pc_d    = pc_q;
            tl_instr_d = imem_instr;
          end
        end
        2'b10: begin
          if (count_q == '0) begin
            hd_pc_d    = pc_q;
            hd_instr_d = imem_instr;
          end else begin
            tl_pc_d    = pc_q;
            tl_instr_d = imem_instr;
          end
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          hd_pc_d    = tl_pc_q;
          hd_instr_d = tl_instr_q;
          count_d    = count_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      hd_pc_q    <= '0;
      hd_instr_q <= NOP;
      tl_pc_q    <= '0;
      tl_instr_q <= NOP;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      hd_pc_q    <= hd_pc_d;
      hd_instr_q <= hd_instr_d;
      tl_pc_q    <= tl_pc_d;
      tl_instr_q <= tl_instr_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
